// File: rtl/encoder_sample_scheduler.sv
// Fixed-window velocity sampler driving two encoder counters. It clears the counters,
// opens the count gate for WIN_CYCLES clocks, then captures both counts into a valid/ready register.
module encoder_sample_scheduler #(
  parameter int CNT_W      = 24,
  parameter int WIN_CYCLES = 1000000,
  parameter int CLR_CYCLES = 2,
  parameter int TMR_W      = 24,
  parameter int SEQ_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [CNT_W-1:0] countL,
  input  logic [CNT_W-1:0] countR,
  output logic             zero_cntrs,
  output logic             sampleModeEn,
  output logic             sampleCntOnOff,
  output logic [CNT_W-1:0] sampleL,
  output logic [CNT_W-1:0] sampleR,
  output logic [SEQ_W-1:0] sample_seq,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SAMPLE  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WIN_CYCLES - 1);

  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;

  assign state_dbg = state;

  // Outputs are decoded from the next state so they line up with the state register.
  // Bit order: {zero_cntrs, sampleModeEn, sampleCntOnOff, busy}
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      CLEAR:   decode = 4'b1101;
      SAMPLE:  decode = 4'b0111;
      SETTLE:  decode = 4'b0101;
      CAPTURE: decode = 4'b0101;
      default: decode = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      IDLE: begin
        if (run_en) begin
          state_next = CLEAR;
          timer_next = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (timer == '0) begin
          state_next = SAMPLE;
          timer_next = WIN_LOAD;
        end else begin
          timer_next = timer - TMR_W'(1);
        end
      end
      SAMPLE: begin
        if (timer == '0) state_next = SETTLE;
        else             timer_next = timer - TMR_W'(1);
      end
      SETTLE:  state_next = CAPTURE;
      CAPTURE: begin
        if (run_en) begin
          state_next = CLEAR;
          timer_next = CLR_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      zero_cntrs     <= 1'b0;
      sampleModeEn   <= 1'b0;
      sampleCntOnOff <= 1'b0;
      busy           <= 1'b0;
      sampleL        <= '0;
      sampleR        <= '0;
      sample_seq     <= '0;
      sample_valid   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      {zero_cntrs, sampleModeEn, sampleCntOnOff, busy} <= decode(state_next);

      // A capture always wins over a concurrent accept: newest data stays valid.
      if (state == CAPTURE) begin
        sampleL      <= countL;
        sampleR      <= countR;
        sample_seq   <= sample_seq + SEQ_W'(1);
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (state == CAPTURE && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// Directed bench for encoder_sample_scheduler with WIN_CYCLES=8 and CLR_CYCLES=2 (12-clock period).
// Model encoders count left +1 and right -1 per clock while the gate is open.
module tb_encoder_sample_scheduler;

  localparam int CNT_W = 24;
  localparam int SEQ_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run_en = 1'b0;
  logic [CNT_W-1:0] countL, countR;
  logic             zero_cntrs, sampleModeEn, sampleCntOnOff;
  logic [CNT_W-1:0] sampleL, sampleR;
  logic [SEQ_W-1:0] sample_seq;
  logic             sample_valid;
  logic             sample_ready = 1'b0;
  logic             overrun;
  logic             overrun_clr = 1'b0;
  logic             busy;
  logic [2:0]       state_dbg;

  int checks = 0;
  int failures = 0;

  encoder_sample_scheduler #(
    .CNT_W(CNT_W), .WIN_CYCLES(8), .CLR_CYCLES(2), .TMR_W(24), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .countL(countL), .countR(countR),
    .zero_cntrs(zero_cntrs), .sampleModeEn(sampleModeEn), .sampleCntOnOff(sampleCntOnOff),
    .sampleL(sampleL), .sampleR(sampleR), .sample_seq(sample_seq),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // encoder models
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      countL <= '0;
      countR <= '0;
    end else if (zero_cntrs) begin
      countL <= '0;
      countR <= '0;
    end else if (sampleCntOnOff) begin
      countL <= countL + 24'd1;
      countR <= countR - 24'd1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({zero_cntrs, sampleModeEn, sampleCntOnOff, busy, sample_valid, overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b expected=000000",
               {zero_cntrs, sampleModeEn, sampleCntOnOff, busy, sample_valid, overrun});
    end
    checks++;
    if ({sampleL, sampleR, sample_seq} !== '0) begin
      failures++;
      $display("FAIL reset_data actual=%h/%h/%h expected=0", sampleL, sampleR, sample_seq);
    end
    #3 rst = 1'b0;
  endtask

  // From run_en=1 the edges go: 1-2 CLEAR, 3-10 SAMPLE, 11 SETTLE, 12 CAPTURE, 13 data valid.
  task automatic test_window_timing;
    logic [3:0] exp_ctrl;
    run_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      exp_ctrl = {(k <= 2 || k == 13), 1'b1, (k >= 3 && k <= 10), 1'b1};
      checks++;
      if ({zero_cntrs, sampleModeEn, sampleCntOnOff, busy} !== exp_ctrl) begin
        failures++;
        $display("FAIL window_ctrl k=%0d actual=%b expected=%b", k,
                 {zero_cntrs, sampleModeEn, sampleCntOnOff, busy}, exp_ctrl);
      end
      checks++;
      if (sample_valid !== (k == 13)) begin
        failures++;
        $display("FAIL window_valid k=%0d actual=%b expected=%b", k, sample_valid, (k == 13));
      end
    end
    checks++;
    if (sample_seq !== 8'd1 || sampleL !== 24'h000008 || sampleR !== 24'hFFFFF8) begin
      failures++;
      $display("FAIL first_sample actual=%h/%h/%h expected=01/000008/fffff8",
               sample_seq, sampleL, sampleR);
    end
  endtask

  task automatic test_overrun;
    tick(12);
    checks++;
    if (overrun !== 1'b1 || sample_valid !== 1'b1 || sample_seq !== 8'd2 || sampleL !== 24'h000008) begin
      failures++;
      $display("FAIL overrun_set actual=%b/%b/%h/%h expected=1/1/02/000008",
               overrun, sample_valid, sample_seq, sampleL);
    end
    tick(11);
    overrun_clr = 1'b1;
    tick(1);
    checks++;
    if (overrun !== 1'b1 || sample_seq !== 8'd3) begin
      failures++;
      $display("FAIL overrun_clr_vs_set actual=%b/%h expected=1/03", overrun, sample_seq);
    end
    tick(1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr actual=%b expected=0", overrun);
    end
    overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    tick(10);
    sample_ready = 1'b1;
    tick(1);
    checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_seq !== 8'd4) begin
      failures++;
      $display("FAIL accept_on_capture actual=%b/%b/%h expected=1/0/04",
               sample_valid, overrun, sample_seq);
    end
    tick(1);
    checks++;
    if (sample_valid !== 1'b0 || sample_seq !== 8'd4) begin
      failures++;
      $display("FAIL accept_plain actual=%b/%h expected=0/04", sample_valid, sample_seq);
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_run_stop;
    tick(3);
    checks++;
    if (sampleCntOnOff !== 1'b1) begin
      failures++;
      $display("FAIL stop_in_sample actual=%b expected=1", sampleCntOnOff);
    end
    run_en = 1'b0;
    tick(8);
    checks++;
    if (sample_valid !== 1'b1 || sample_seq !== 8'd5 || sampleL !== 24'h000008 || sampleR !== 24'hFFFFF8) begin
      failures++;
      $display("FAIL stop_capture actual=%b/%h/%h/%h expected=1/05/000008/fffff8",
               sample_valid, sample_seq, sampleL, sampleR);
    end
    checks++;
    if ({zero_cntrs, sampleModeEn, sampleCntOnOff, busy} !== 4'b0 || state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL stop_idle actual=%b/%0d expected=0000/0",
               {zero_cntrs, sampleModeEn, sampleCntOnOff, busy}, state_dbg);
    end
    tick(5);
    checks++;
    if (busy !== 1'b0 || sample_seq !== 8'd5 || zero_cntrs !== 1'b0) begin
      failures++;
      $display("FAIL stop_stays_idle actual=%b/%h/%b expected=0/05/0", busy, sample_seq, zero_cntrs);
    end
  endtask

  task automatic test_async_reset;
    run_en = 1'b1;
    tick(5);
    checks++;
    if (sampleCntOnOff !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_gate actual=%b expected=1", sampleCntOnOff);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({zero_cntrs, sampleModeEn, sampleCntOnOff, busy, sample_valid, overrun} !== 6'b0 ||
        sample_seq !== 8'd0 || sampleL !== 24'd0) begin
      failures++;
      $display("FAIL async_reset actual=%b/%h/%h expected=000000/00/000000",
               {zero_cntrs, sampleModeEn, sampleCntOnOff, busy, sample_valid, overrun},
               sample_seq, sampleL);
    end
    rst = 1'b0;
    tick(12);
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_early actual=%b expected=0", sample_valid);
    end
    tick(1);
    checks++;
    if (sample_valid !== 1'b1 || sample_seq !== 8'd1 || sampleL !== 24'h000008 || sampleR !== 24'hFFFFF8) begin
      failures++;
      $display("FAIL restart_sample actual=%b/%h/%h/%h expected=1/01/000008/fffff8",
               sample_valid, sample_seq, sampleL, sampleR);
    end
    run_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_window_timing();
    test_overrun();
    test_back_to_back();
    test_run_stop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_sample_scheduler.md
Name: encoder_sample_scheduler

Overview:
Sequences two encoder_cntr_module instances (left/right wheel) for fixed-window velocity sampling.
- Per window: pulses zero_cntrs, opens the count gate for exactly WIN_CYCLES clocks, closes it, then captures both counts into a valid/ready output register.
- Sits between the encoder counters and the motor PID / telemetry consumer.
- Gives the consumer a signed tick delta per window at a fixed period.

Parameters:
CNT_W, 24, width of encoder count inputs and sample outputs.
WIN_CYCLES, 1000000, clocks the count gate is open per window (10 ms at 100 MHz); must be >= 2.
CLR_CYCLES, 2, clocks zero_cntrs is held high per window; must be >= 1.
TMR_W, 24, width of internal window/clear timer; must hold WIN_CYCLES-1.
SEQ_W, 8, width of sample sequence counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run_en  in  1  level; 1 = schedule windows back-to-back
countL  in  CNT_W  left encoder count
countR  in  CNT_W  right encoder count
zero_cntrs  out  1  to both encoders; clears counters
sampleModeEn  out  1  to both encoders; 1 = gated sampling mode
sampleCntOnOff  out  1  to both encoders; 1 = gate open
sampleL  out  CNT_W  captured left delta, two's complement
sampleR  out  CNT_W  captured right delta, two's complement
sample_seq  out  SEQ_W  increments on every capture
sample_valid  out  1  sample register holds unconsumed data
sample_ready  in  1  consumer accepts when valid & ready
overrun  out  1  sticky; a capture overwrote unconsumed data
overrun_clr  in  1  synchronous clear of overrun
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, timer=0, all outputs 0 (sampleL/R, sample_seq, valid, overrun, zero_cntrs, sampleModeEn, sampleCntOnOff, busy). Reset mid-window abandons the window; no capture.
- All outputs are registered and are a function of the state register.
  - IDLE: zero_cntrs=0, sampleModeEn=0, gate=0.
  - CLEAR: zero_cntrs=1, sampleModeEn=1, gate=0.
  - SAMPLE: zero_cntrs=0, sampleModeEn=1, gate=1.
  - SETTLE / CAPTURE: zero_cntrs=0, sampleModeEn=1, gate=0.
- IDLE: if run_en=1 -> CLEAR; load timer=CLR_CYCLES-1.
- CLEAR: decrement timer; at 0 -> SAMPLE; load timer=WIN_CYCLES-1.
- SAMPLE: decrement timer; at 0 -> SETTLE. Gate is high for exactly WIN_CYCLES clocks.
- SETTLE: 1 clock; lets the last gated count update land -> CAPTURE.
- CAPTURE: 1 clock.
  - sampleL<=countL, sampleR<=countR, sample_seq<=sample_seq+1 (wraps modulo 2^SEQ_W), sample_valid<=1.
  - If sample_valid was 1 and not being accepted this cycle: overrun<=1 and data is overwritten (newest wins).
  - Next: run_en=1 -> CLEAR (timer=CLR_CYCLES-1); else -> IDLE.
- Window period with run_en held high: CLR_CYCLES+WIN_CYCLES+2 clocks, constant regardless of sample_ready.
- run_en is sampled only in IDLE and CAPTURE. Deassertion mid-window completes the current window and its capture, then goes IDLE.
- Handshake:
  - Accept = sample_valid & sample_ready at a clock edge; sample_valid<=0 next cycle unless CAPTURE coincides.
  - CAPTURE on the same cycle as an accept: valid stays 1 with new data, no overrun.
  - sampleL/R/seq are stable while valid=1, except on overrun overwrite.
- overrun: set on overwrite, cleared by overrun_clr. Simultaneous set and clear -> set wins.
- Arithmetic: no saturation. Deltas are raw CNT_W two's complement (counters start at 0 each window); the consumer interprets them as signed.

Test Plan:
- Bench params WIN_CYCLES=8, CLR_CYCLES=2, so period = 12.
- rst, then run_en=1 -> zero_cntrs high 2 clocks, then sampleCntOnOff high exactly 8 clocks, then 2 clocks gate low, then sample_valid=1, sample_seq=1; the pattern repeats every 12 clocks.
- Model counters: left advances +1/clk, right -1/clk while gate is open -> sampleL=24'h000008, sampleR=24'hFFFFF8.
- sample_ready held 0 across two captures -> overrun=1, sample_seq=2, second data present. overrun_clr and a CAPTURE in the same cycle -> overrun stays 1. overrun_clr alone -> 0.
- sample_ready=1 asserted exactly on a CAPTURE cycle with valid=1 -> no overrun, valid stays 1, new data.
- run_en dropped at the 3rd SAMPLE clock -> window completes, one capture occurs, then IDLE; busy=0 and all gate/zero outputs 0.
- rst pulsed mid-SAMPLE -> all outputs 0 immediately (async), no capture. Re-enable restarts with sample_seq=1.
